// File: rtl/updown_mod_counter_if.sv
// Bus bundle for the cascadable up/down modulo counter stage.
// The master drives control and load data; the slave is the counter itself.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             enp;
    logic             ent;
    logic             up;
    logic             oneshot;
    logic             wrap_clr;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             rco;
    logic             wrap;
    logic             done;

    modport master (
        output load, d, enp, ent, up, oneshot, wrap_clr,
        input  q, tc, rco, wrap, done
    );

    modport slave (
        input  load, d, enp, ent, up, oneshot, wrap_clr,
        output q, tc, rco, wrap, done
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Synchronous WIDTH-bit up/down counter, modulo MODULUS, with 74161-style cascade
// enables, parallel load, one-shot stop-at-terminal mode and a sticky wrap flag.
module updown_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    updown_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(MODULUS - 1);

    // Anything at or above the terminal value (including out-of-range loads) restarts at zero.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v >= TERM_VAL) begin
            r = ZERO_VAL;
        end else begin
            r = v + ONE_VAL;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ((v == ZERO_VAL) || (v > TERM_VAL)) begin
            r = TERM_VAL;
        end else begin
            r = v - ONE_VAL;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] v,
                                                    input logic             dir_up);
        logic [WIDTH-1:0] r;
        if (dir_up) begin
            r = step_up(v);
        end else begin
            r = step_down(v);
        end
        return r;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             done_r;

    logic             tc_s;
    logic             count_en_s;
    logic             wrap_set_s;
    logic             wrap_next_s;
    logic             done_next_s;
    logic [WIDTH-1:0] q_next_s;

    // Terminal count depends on direction; out-of-range values never match either end.
    always_comb begin
        tc_s = 1'b0;
        if (bus.up) begin
            tc_s = (q_r == TERM_VAL);
        end else begin
            tc_s = (q_r == ZERO_VAL);
        end
    end

    assign count_en_s = bus.load & bus.enp & bus.ent & ~(bus.oneshot & done_r);

    // Next-state selection: load beats count beats hold; a terminal step in one-shot mode freezes q.
    always_comb begin
        q_next_s    = q_r;
        done_next_s = done_r;
        wrap_set_s  = 1'b0;
        if (!bus.load) begin
            q_next_s    = bus.d;
            done_next_s = 1'b0;
        end else if (count_en_s) begin
            if (tc_s) begin
                wrap_set_s = 1'b1;
                if (bus.oneshot) begin
                    done_next_s = 1'b1;
                end else begin
                    q_next_s = count_step(q_r, bus.up);
                end
            end else begin
                q_next_s = count_step(q_r, bus.up);
            end
        end else begin
            q_next_s    = q_r;
            done_next_s = done_r;
        end
    end

    // A wrap event on the same edge as wrap_clr keeps the flag set.
    always_comb begin
        wrap_next_s = wrap_set_s | (wrap_r & ~bus.wrap_clr);
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r    <= ZERO_VAL;
            wrap_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
            done_r <= done_next_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.done = done_r;
    assign bus.tc   = tc_s;
    assign bus.rco  = tc_s & bus.ent;
endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised synchronous successor to the 4-bit presettable ripple binary counter family.
- WIDTH-bit counter, modulo MODULUS (binary or decade), with up/down direction, synchronous parallel load, 74161-style cascade enables (enp/ent) and ripple carry output.
- Adds behaviour the ripple part lacks: a one-shot stop-at-terminal mode, a sticky wrap flag, and defined recovery from out-of-range load values.
- Used as a drop-in cascadable counter stage in TTL-level system models.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH (10 = decade, 16 = binary).

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-low reset/clear
- load  input  1  synchronous parallel load, active-low
- d  input  WIDTH  parallel load data
- enp  input  1  count enable P (active-high)
- ent  input  1  count enable T, cascade input (active-high)
- up  input  1  direction: 1 = up, 0 = down
- oneshot  input  1  mode: 0 = free-run wrap, 1 = stop at terminal count
- wrap_clr  input  1  synchronous clear of the wrap flag, active-high
- q  output  WIDTH  counter value
- tc  output  1  terminal count (combinational)
- rco  output  1  ripple carry out = tc & ent (combinational)
- wrap  output  1  sticky flag, set on wrap-around
- done  output  1  one-shot completion flag

Behaviour:
- Reset:
  - clr=0 asynchronously forces q=0, wrap=0, done=0, independent of clk.
  - Outputs hold these values while clr=0.
  - Counting resumes on the first rising clk after clr returns high.
- Priority at each rising clk (clr=1): load > count > hold.
- Load (load=0):
  - q <= d on the clock edge, regardless of enp/ent/done.
  - Clears done.
  - Does not touch wrap.
  - d >= MODULUS is loaded unchanged (out-of-range).
- Count condition: load=1 & enp=1 & ent=1 & !(oneshot & done).
- tc, combinational:
  - up=1: tc = (q == MODULUS-1).
  - up=0: tc = (q == 0).
  - Out-of-range q never asserts tc.
- Up count:
  - q < MODULUS-1: q+1.
  - q >= MODULUS-1: q becomes 0 (covers both terminal and out-of-range recovery, so recovery takes one clock).
- Down count:
  - q == 0: q becomes MODULUS-1.
  - q > MODULUS-1: q becomes MODULUS-1.
  - Otherwise: q-1.
- Wrap, free-run (oneshot=0): a count step taken while tc=1 wraps the counter and sets wrap=1 on the same edge.
- One-shot (oneshot=1):
  - A count step taken while tc=1 leaves q unchanged and sets done=1 (and wrap=1).
  - Further counting is inhibited while done=1.
  - Only load or clr restarts the counter.
- Mode changes:
  - oneshot 1->0 with done=1: done remains 1 but no longer inhibits counting; done is cleared only by load or clr.
  - Direction may change on any cycle; tc follows up combinationally.
- wrap_clr:
  - wrap_clr=1 clears wrap on the edge.
  - If a wrap event occurs on the same edge, set wins (wrap=1).
- Cascade:
  - rco = tc & ent, not gated by enp.
  - Stage n+1's ent connects to stage n's rco; all stages share clk.
  - A chain of decade stages therefore counts BCD synchronously.
- The counter never outputs X after reset, even if d was X while load=1.
- Latency: all registered outputs update on the edge; tc and rco are valid after combinational settle.

Test Plan:
- Async clear: WIDTH=4, MODULUS=16. Count to q=0111, pulse clr=0 between clock edges -> q=0000, wrap=0, done=0 immediately, before the next edge.
- Binary up wrap: load d=1101, then enp=ent=up=1, 3 clocks -> q=1110, 1111 (tc=rco=1), 0000 with wrap=1; wrap_clr pulse -> wrap=0.
- Decade down:
  - MODULUS=10, load d=0001, up=0, 2 clocks -> q=0000 (tc=1), then 1001 with wrap=1.
  - load d=1100, 1 down clock -> q=1001.
- Out-of-range up: MODULUS=10, load d=1111 -> tc=0; one up clock -> q=0000.
- One-shot: MODULUS=10, oneshot=1, load 0111, count up -> 1000, 1001 (tc=1); next clock -> q stays 1001, done=1; 3 more clocks -> q unchanged; load d=0000 -> done=0, counting resumes.
- Cascade: two MODULUS=10 stages, low stage rco to high stage ent, start at 09 -> one clock gives 10; ent=0 on the low stage freezes both stages and forces rco=0.
